aiv_sync_generator: RTL and testbench
=====================================

# aiv_sync_generator

Generates the AIV PAL video timing from the 81 MHz system clock: 13.5 MHz dot enable, single-cycle `hsync` and `vsync` strobes, `odd_field`, a 4.74 µs line-sync level and a blanking flag. It is the transmit-side counterpart of the AIV pixel/line/dot tracking logic. Its strobes drive those trackers directly, so the trackers report active lines 23..310 and active dots 72..791 with no external adjustment. The block is the single timing master for the AIV output path.

## Interface
- `CLK_DIV`, 6: clk cycles per dot; 81 MHz / 6 = 13.5 MHz.
- `H_TOTAL`, 864: dots per line.
- `H_SYNC_DOTS`, 64: width of the `hsync_n` low period, in dots.
- `FRAME_LINES`, 625: lines per frame. Field 1 (odd) is 313 lines; field 2 (even) is 312 lines.
- `ACTIVE_H_START`, 72: first active dot.
- `ACTIVE_H_DOTS`, 720: number of active dots.
- `ACTIVE_V_START`, 23: first active field line.
- `ACTIVE_V_LINES`, 288: number of active lines per field.

Ports (reset is synchronous and active-low, sampled on the rising edge of `clk`):
- `clk` input 1: 81 MHz clock.
- `rst_n` input 1: synchronous active-low reset.
- `run` input 1: timing advances only while this is 1.
- `dot_ce` output 1: one-clk pulse, once per dot.
- `hsync` output 1: one-clk pulse at the start of each line.
- `vsync` output 1: one-clk pulse at the start of each field.
- `odd_field` output 1: 1 during field 1, 0 during field 2.
- `hsync_n` output 1: line-sync level, low for dots 0..H_SYNC_DOTS-1.
- `blank` output 1: 1 outside the active window.
- `field_line` output 10: line within the current field; 0..312 or 0..311.

## Operation
- Internal counters:
  - `phase`, 3 bits, 0..CLK_DIV-1.
  - `dot`, 10 bits, 0..863.
  - `frame_line`, 10 bits, 0..624.
- Counters advance once per clk while `run`=1:
  - `phase` wraps at 5; `dot` increments when `phase`=5.
  - `dot` wraps 863→0; `frame_line` increments when `dot` wraps.
  - `frame_line` wraps 624→0.
- `field_line` = `frame_line` for 0..312, and `frame_line`-313 for 313..624.
- `odd_field` = 1 when `frame_line` ≤ 312.
- Decode from the counter state:
  - `dot_ce`: `phase`=0.
  - `hsync`: `dot`=0 and `phase`=0.
  - `vsync`: `dot`=0, `phase`=1, and `frame_line` ∈ {0, 313}. It fires one clk after `hsync` and must never coincide with it; a downstream tracker gives `hsync` priority over `vsync`, so a coincident pulse would break the field reset.
  - `hsync_n`: 0 when `dot` < H_SYNC_DOTS.
  - `blank`: 0 only when `dot` ∈ [72, 791] and `field_line` ∈ [23, 310]; otherwise 1.
- When `run`=0:
  - All counters hold.
  - `dot_ce`, `hsync` and `vsync` are forced to 0.
  - `hsync_n`, `blank`, `odd_field` and `field_line` hold their last values.
  - When `run` returns to 1, counting resumes from the held state. No pulse is replayed or skipped, except that a pulse due in the stall cycle appears one cycle later.
- Reset while `rst_n`=0:
  - Counters are set to 0.
  - Outputs are: `dot_ce`=0, `hsync`=0, `vsync`=0, `odd_field`=0, `hsync_n`=1, `blank`=1, `field_line`=0.
  - Reset mid-line or mid-field is immediate and takes priority over `run`. No partial pulse is emitted.

## Timing
- Every output is registered from the counter state, with a latency of 1 clk.
- After `rst_n` is first sampled high with `run`=1, the first `hsync` and `dot_ce` are high in the cycle following the next rising edge. `vsync` follows one clk later, with `odd_field`=1.
- Pulse spacing:
  - `hsync` period: 5184 clk (64 µs).
  - `dot_ce` period: 6 clk.
  - `hsync_n` low: 384 clk.
- `vsync` spacing alternates: 313×5184 = 1,622,592 clk (end of field 1), then 312×5184 = 1,617,408 clk. The frame is 3,240,000 clk (40 ms).
- `odd_field` changes in the same cycle that `vsync` is high.
- `field_line` changes in the cycle `hsync` is high.

## Test plan
- Reset release, `run`=1:
  - `hsync` appears one cycle after release.
  - `vsync` appears the following cycle.
  - `odd_field`=1 from the `vsync` cycle onward.
  - `hsync`/`vsync` never high in the same cycle over 2 frames.
- Line period:
  - Consecutive `hsync` pulses are exactly 5184 clk apart.
  - There are exactly 864 `dot_ce` pulses per line.
  - `hsync_n` is low for 384 clk starting on the `hsync` cycle.
- Field structure:
  - Between `vsync` pulses, count 313 `hsync` pulses with `odd_field`=1, then 312 with `odd_field`=0.
  - `field_line` peaks at 312 and then 311.
- Active window:
  - `blank`=0 in exactly 720×288 = 207,360 `dot_ce` cycles per field.
  - The first unblanked dot is at `field_line` 23, dot 72; the last is at `field_line` 310, dot 791.
  - Connected to the AIV pixel tracker, it yields `pixel_x` 0..719 and `pixel_y` 0..575.
- `run` stall:
  - Drop `run` for 100 clk mid-line: no pulses are emitted during the stall.
  - The next `hsync` is delayed by exactly 100 clk.
  - `field_line` and `blank` hold their values through the stall.
- Mid-field reset:
  - Assert `rst_n`=0 for 3 clk at `frame_line` 200: outputs take their reset values from the next cycle.
  - After release, timing restarts at `frame_line` 0 with `odd_field`=1.

Source files
------------

// File: rtl/aiv_sync_generator.sv
// AIV PAL timing master: dot enable, line/field strobes, sync level and blanking.
// All outputs are registered decodes of the phase/dot/line counters (1 clk latency).
module aiv_sync_generator #(
  parameter int unsigned CLK_DIV        = 6,
  parameter int unsigned H_TOTAL        = 864,
  parameter int unsigned H_SYNC_DOTS    = 64,
  parameter int unsigned FRAME_LINES    = 625,
  parameter int unsigned ACTIVE_H_START = 72,
  parameter int unsigned ACTIVE_H_DOTS  = 720,
  parameter int unsigned ACTIVE_V_START = 23,
  parameter int unsigned ACTIVE_V_LINES = 288
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       dot_ce,
  output logic       hsync,
  output logic       vsync,
  output logic       odd_field,
  output logic       hsync_n,
  output logic       blank,
  output logic [9:0] field_line
);

  // Field 1 carries the extra (odd) line of the frame.
  localparam logic [2:0] PhaseLast  = 3'(CLK_DIV - 1);
  localparam logic [9:0] DotLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] LineLast   = 10'(FRAME_LINES - 1);
  localparam logic [9:0] F1Lines    = 10'((FRAME_LINES + 1) / 2);
  localparam logic [9:0] HSyncDots  = 10'(H_SYNC_DOTS);
  localparam logic [9:0] HActStart  = 10'(ACTIVE_H_START);
  localparam logic [9:0] HActEnd    = 10'(ACTIVE_H_START + ACTIVE_H_DOTS);
  localparam logic [9:0] VActStart  = 10'(ACTIVE_V_START);
  localparam logic [9:0] VActEnd    = 10'(ACTIVE_V_START + ACTIVE_V_LINES);

  logic [2:0] phase_q;
  logic [9:0] dot_q;
  logic [9:0] frame_line_q;

  logic [9:0] cur_field_line;
  logic       line_start;
  logic       field_start;
  logic       active;

  // Decode the current counter state; vsync sits on phase 1 so it never meets hsync.
  always_comb begin
    cur_field_line = (frame_line_q >= F1Lines) ? (frame_line_q - F1Lines) : frame_line_q;
    line_start     = (phase_q == 3'd0) && (dot_q == 10'd0);
    field_start    = (phase_q == 3'd1) && (dot_q == 10'd0) &&
                     ((frame_line_q == 10'd0) || (frame_line_q == F1Lines));
    active         = (dot_q >= HActStart) && (dot_q < HActEnd) &&
                     (cur_field_line >= VActStart) && (cur_field_line < VActEnd);
  end

  // Phase/dot/line counters; they freeze while run is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q      <= 3'd0;
      dot_q        <= 10'd0;
      frame_line_q <= 10'd0;
    end else if (run) begin
      if (phase_q == PhaseLast) begin
        phase_q <= 3'd0;
        if (dot_q == DotLast) begin
          dot_q        <= 10'd0;
          frame_line_q <= (frame_line_q == LineLast) ? 10'd0 : frame_line_q + 10'd1;
        end else begin
          dot_q <= dot_q + 10'd1;
        end
      end else begin
        phase_q <= phase_q + 3'd1;
      end
    end
  end

  // Registered outputs; strobes are suppressed and levels held while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dot_ce     <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      odd_field  <= 1'b0;
      hsync_n    <= 1'b1;
      blank      <= 1'b1;
      field_line <= 10'd0;
    end else if (run) begin
      dot_ce  <= (phase_q == 3'd0);
      hsync   <= line_start;
      vsync   <= field_start;
      hsync_n <= (dot_q >= HSyncDots);
      blank   <= !active;
      // field_line steps with hsync, odd_field with vsync.
      if (line_start) begin
        field_line <= cur_field_line;
      end
      if (field_start) begin
        odd_field <= (frame_line_q == 10'd0);
      end
    end else begin
      dot_ce <= 1'b0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aiv_sync_generator.sv
// Bench for aiv_sync_generator: a reduced-geometry instance and a full PAL instance
// share one stimulus stream and are compared every cycle against a time-based model.
module tb_aiv_sync_generator;

  logic clk = 1'b0;
  logic rst_n;
  logic run;

  logic       dot_ce_s, hsync_s, vsync_s, odd_s, hsync_n_s, blank_s;
  logic [9:0] field_line_s;
  logic       dot_ce_f, hsync_f, vsync_f, odd_f, hsync_n_f, blank_f;
  logic [9:0] field_line_f;

  typedef struct {
    logic       dot_ce;
    logic       hsync;
    logic       vsync;
    logic       odd;
    logic       hsync_n;
    logic       blank;
    logic [9:0] field_line;
  } outs_t;

  int    checks = 0;
  int    errors = 0;
  int    t = 0;
  outs_t exp_s;
  outs_t exp_f;

  always #5 clk = ~clk;

  aiv_sync_generator #(
    .CLK_DIV(3), .H_TOTAL(20), .H_SYNC_DOTS(4), .FRAME_LINES(11),
    .ACTIVE_H_START(3), .ACTIVE_H_DOTS(12), .ACTIVE_V_START(1), .ACTIVE_V_LINES(3)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .run(run),
    .dot_ce(dot_ce_s), .hsync(hsync_s), .vsync(vsync_s), .odd_field(odd_s),
    .hsync_n(hsync_n_s), .blank(blank_s), .field_line(field_line_s)
  );

  aiv_sync_generator dut_f (
    .clk(clk), .rst_n(rst_n), .run(run),
    .dot_ce(dot_ce_f), .hsync(hsync_f), .vsync(vsync_f), .odd_field(odd_f),
    .hsync_n(hsync_n_f), .blank(blank_f), .field_line(field_line_f)
  );

  function automatic outs_t reset_outs();
    outs_t o;
    o.dot_ce = 0; o.hsync = 0; o.vsync = 0; o.odd = 0;
    o.hsync_n = 1; o.blank = 1; o.field_line = 0;
    return o;
  endfunction

  // Outputs after the run-edge numbered tt (counted from reset), from raster arithmetic.
  function automatic outs_t model(int tt, int div, int htot, int hsd, int lines,
                                  int ahs, int ahd, int avs, int avl);
    outs_t o;
    int line_clk, p, line, r, dt, ph, f1, fl;
    bit start_of_field_line;
    line_clk = div * htot;
    p   = tt % (line_clk * lines);
    line = p / line_clk;
    r   = p % line_clk;
    dt  = r / div;
    ph  = r % div;
    f1  = (lines + 1) / 2;
    fl  = (line < f1) ? line : line - f1;
    start_of_field_line = (line == 0) || (line == f1);
    o.dot_ce     = (ph == 0);
    o.hsync      = (ph == 0) && (dt == 0);
    o.vsync      = (ph == 1) && (dt == 0) && start_of_field_line;
    // odd_field flips only on the vsync cycle, so the preceding hsync cycle shows the old value.
    o.odd        = (line < f1) ^ ((ph == 0) && (dt == 0) && start_of_field_line);
    o.hsync_n    = (dt >= hsd);
    o.blank      = !((dt >= ahs) && (dt < ahs + ahd) && (fl >= avs) && (fl < avs + avl));
    o.field_line = 10'(fl);
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      exp_s = reset_outs();
      exp_f = reset_outs();
      t = 0;
    end else if (run) begin
      exp_s = model(t, 3, 20, 4, 11, 3, 12, 1, 3);
      exp_f = model(t, 6, 864, 64, 625, 72, 720, 23, 288);
      t++;
    end else begin
      exp_s.dot_ce = 0; exp_s.hsync = 0; exp_s.vsync = 0;
      exp_f.dot_ce = 0; exp_f.hsync = 0; exp_f.vsync = 0;
    end
    #1;
    check("s_dot_ce", 32'(dot_ce_s), 32'(exp_s.dot_ce));
    check("s_hsync", 32'(hsync_s), 32'(exp_s.hsync));
    check("s_vsync", 32'(vsync_s), 32'(exp_s.vsync));
    check("s_odd_field", 32'(odd_s), 32'(exp_s.odd));
    check("s_hsync_n", 32'(hsync_n_s), 32'(exp_s.hsync_n));
    check("s_blank", 32'(blank_s), 32'(exp_s.blank));
    check("s_field_line", 32'(field_line_s), 32'(exp_s.field_line));
    check("f_dot_ce", 32'(dot_ce_f), 32'(exp_f.dot_ce));
    check("f_hsync", 32'(hsync_f), 32'(exp_f.hsync));
    check("f_vsync", 32'(vsync_f), 32'(exp_f.vsync));
    check("f_odd_field", 32'(odd_f), 32'(exp_f.odd));
    check("f_hsync_n", 32'(hsync_n_f), 32'(exp_f.hsync_n));
    check("f_blank", 32'(blank_f), 32'(exp_f.blank));
    check("f_field_line", 32'(field_line_f), 32'(exp_f.field_line));
  endtask

  initial begin
    int nhs, gap, dce, hnl, hs_cnt, act, maxfl, nf, cnt;
    bit have, odd_prev, found;
    logic [9:0] fl_hold;
    logic       blank_hold;

    exp_s = reset_outs();
    exp_f = reset_outs();

    // Reset state.
    rst_n = 0; run = 0;
    repeat (3) tick();

    // Release with run: hsync next cycle, vsync one after with odd_field set.
    rst_n = 1; run = 1;
    tick();
    check("rel_hsync", 32'(hsync_f), 1);
    check("rel_dot_ce", 32'(dot_ce_f), 1);
    check("rel_no_vsync", 32'(vsync_f), 0);
    tick();
    check("rel_vsync", 32'(vsync_f), 1);
    check("rel_odd", 32'(odd_f), 1);
    check("rel_hsync_off", 32'(hsync_f), 0);

    // Full-size line: period, dot count and sync width.
    nhs = 0; gap = 0; dce = 0; hnl = 0;
    for (int i = 0; i < 12000 && nhs < 2; i++) begin
      tick();
      if (hsync_f) nhs++;
      if (nhs == 1) begin
        gap++;
        dce += int'(dot_ce_f);
        hnl += int'(!hsync_n_f);
      end
    end
    check("line_seen", 32'(nhs), 2);
    check("line_period", 32'(gap), 5184);
    check("dots_per_line", 32'(dce), 864);
    check("hsync_n_low", 32'(hnl), 384);

    // Reduced-geometry field structure: 6/5 lines, 12x3 active dots per field.
    have = 0; odd_prev = 0; nf = 0; hs_cnt = 0; act = 0; maxfl = 0;
    for (int i = 0; i < 3000 && nf < 4; i++) begin
      tick();
      if (vsync_s) begin
        if (have) begin
          check("field_hsyncs", 32'(hs_cnt), odd_prev ? 6 : 5);
          check("field_active", 32'(act), 36);
          check("field_line_peak", 32'(maxfl), odd_prev ? 5 : 4);
          nf++;
        end
        have = 1; odd_prev = odd_s; hs_cnt = 0; act = 0; maxfl = 0;
      end
      hs_cnt += int'(hsync_s);
      act += int'(dot_ce_s && !blank_s);
      if (int'(field_line_s) > maxfl) maxfl = int'(field_line_s);
    end
    check("fields_seen", 32'(nf), 4);

    // 100-clk stall mid-line delays the next hsync by exactly 100.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (hsync_s) found = 1;
    end
    check("stall_sync_found", 32'(found), 1);
    repeat (20) tick();
    fl_hold = field_line_s; blank_hold = blank_s;
    run = 0;
    repeat (100) tick();
    check("stall_field_line", 32'(field_line_s), 32'(fl_hold));
    check("stall_blank", 32'(blank_s), 32'(blank_hold));
    run = 1;
    cnt = 120; found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      cnt++;
      if (hsync_s) found = 1;
    end
    check("stall_next_hsync", 32'(found), 1);
    check("stall_gap", 32'(cnt), 160);

    // Mid-field reset, then restart at line 0 of field 1.
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (odd_s && field_line_s == 10'd3) found = 1;
    end
    check("reset_point_found", 32'(found), 1);
    rst_n = 0;
    repeat (3) tick();
    check("mid_reset_odd", 32'(odd_s), 0);
    check("mid_reset_hsync_n", 32'(hsync_n_s), 1);
    rst_n = 1;
    tick();
    check("restart_hsync", 32'(hsync_s), 1);
    check("restart_field_line", 32'(field_line_s), 0);
    tick();
    check("restart_vsync", 32'(vsync_s), 1);
    check("restart_odd", 32'(odd_s), 1);

    // Random run stalls and occasional resets against the model.
    for (int i = 0; i < 8000; i++) begin
      run = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1; run = 1;
    repeat (700) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
